// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_responder_pkg;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unsigned width codes exist only for loads
  function automatic logic funct3_illegal(input logic [2:0] f3, input logic we);
    return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (!we && ((f3 == F3_BU) || (f3 == F3_HU))));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store masks/replication, load extension, alignment checks.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c,
  output logic        misalign_c,
  output logic        illegal_c
);

  logic [31:0] shifted;

  // Select lanes by width code and low address bits
  always_comb begin
    byte_en_c  = '0;
    wdata_c    = wdata;
    rdata_c    = '0;
    misalign_c = 1'b0;
    illegal_c  = funct3_illegal(funct3, we);
    shifted    = rword >> {addr_lo, 3'b000};
    case (funct3)
      F3_B, F3_BU: begin
        byte_en_c = 4'b0001 << addr_lo;
        wdata_c   = {4{wdata[7:0]}};
        rdata_c   = funct3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        misalign_c = addr_lo[0];
        byte_en_c  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{wdata[15:0]}};
        rdata_c    = funct3[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        misalign_c = (addr_lo != 2'b00);
        byte_en_c  = 4'b1111;
        rdata_c    = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, configurable wait states, byte-lane stores.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   accept;
  logic                   enter_resp;

  logic [31:0]            cap_addr;
  logic                   cap_we;
  logic [2:0]             cap_funct3;
  logic [31:0]            cap_wdata;

  logic [31:0]            cur_addr;
  logic                   cur_we;
  logic [2:0]             cur_funct3;
  logic [31:0]            cur_wdata;

  logic [IDX_W-1:0]       word_idx;
  logic                   out_of_range;
  logic [3:0]             byte_en;
  logic [31:0]            wdata_rep;
  logic [31:0]            rdata_ext;
  logic                   misalign;
  logic                   illegal;
  logic                   err;
  logic                   mem_we;

  logic [31:0]            mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accepting edge, so use live inputs in IDLE
  always_comb begin
    cur_addr   = cap_addr;
    cur_we     = cap_we;
    cur_funct3 = cap_funct3;
    cur_wdata  = cap_wdata;
    if (state_q == ST_IDLE) begin
      cur_addr   = req_addr;
      cur_we     = req_we;
      cur_funct3 = req_funct3;
      cur_wdata  = req_wdata;
    end
  end

  assign word_idx     = cur_addr[IDX_W+1:2];
  assign out_of_range = (cur_addr[31:2] >= 30'(DEPTH_WORDS));

  dmem_lane_align u_lane_align (
    .funct3     (cur_funct3),
    .we         (cur_we),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rword      (mem[word_idx]),
    .byte_en_c  (byte_en),
    .wdata_c    (wdata_rep),
    .rdata_c    (rdata_ext),
    .misalign_c (misalign),
    .illegal_c  (illegal)
  );

  assign err = illegal || misalign || out_of_range;

  // Next-state and wait counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
  end

  assign mem_we = enter_resp && cur_we && !err;

  // State register and registered handshake/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RESP);
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur_we) ? '0 : rdata_ext;
      end
    end
  end

  // Request capture at accept; later input changes do not reach the transaction
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_addr   <= req_addr;
      cap_we     <= req_we;
      cap_funct3 <= req_funct3;
      cap_wdata  <= req_wdata;
    end
  end

  // Storage array: per-byte writes, never cleared, suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (WAIT_STATES=1 main instance, WAIT_STATES=0 side instance).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;
  logic        req_valid_a, req_valid_b;

  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [0:1023];

  assign req_valid_a = req_valid & ~sel;
  assign req_valid_b = req_valid & sel;
  assign req_ready_m = sel ? req_ready_b : req_ready_a;
  assign rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err_m   = sel ? rsp_err_b   : rsp_err_a;
  assign rsp_rdata_m = sel ? rsp_rdata_b : rsp_rdata_a;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Byte-addressed reference: 1 KiB, little-endian, width/alignment rules as plain arithmetic
  task automatic model(input logic [31:0] a, input logic we, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int sz;
    logic [31:0] v;
    sz = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    er = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) ||
         ((a & 32'(sz - 1)) != 32'd0) || (a >= 32'd1024);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[a[9:0] + 10'(i)] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a[9:0] + 10'(i)]) << (8*i));
        if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
        rd = v;
      end
    end
  endtask

  // One full request/response handshake with optional back-pressure cycles
  task automatic txn(input string name, input logic [31:0] a, input logic we, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold, input logic [31:0] exp_rd, input logic exp_er);
    int n;
    int lat;
    int exp_lat;
    exp_lat = sel ? 1 : 2;
    n = 0;
    while (!req_ready_m && n < 50) begin @(negedge clk); n++; end
    chk({name, " req_ready"}, 32'(req_ready_m), 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_we     = we;
    req_funct3 = f3;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom();
    req_we     = 1'($urandom());
    req_funct3 = 3'($urandom());
    req_wdata  = $urandom();
    lat = 1;
    while (!rsp_valid_m && lat < 50) begin @(negedge clk); lat++; end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " rdata"}, rsp_rdata_m, exp_rd);
    chk({name, " err"}, 32'(rsp_err_m), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_addr   = 32'h14;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_wdata  = 32'h5555AAAA;
      @(negedge clk);
      chk({name, " hold valid"}, 32'(rsp_valid_m), 32'd1);
      chk({name, " hold rdata"}, rsp_rdata_m, exp_rd);
      chk({name, " hold req_ready"}, 32'(req_ready_m), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({name, " post valid"}, 32'(rsp_valid_m), 32'd0);
    chk({name, " post req_ready"}, 32'(req_ready_m), 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] m_rd;
    logic        m_er;
    logic [31:0] a;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wd;

    vecs[0]  = '{32'h10,  1'b1, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{32'h10,  1'b0, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h11,  1'b1, 3'b000, 32'h00000080, 32'h00000000, 1'b0};
    vecs[3]  = '{32'h11,  1'b0, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{32'h11,  1'b0, 3'b100, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{32'h10,  1'b0, 3'b010, 32'h0,        32'hDEAD80EF, 1'b0};
    vecs[6]  = '{32'h13,  1'b0, 3'b001, 32'h0,        32'h00000000, 1'b1};
    vecs[7]  = '{32'h12,  1'b1, 3'b010, 32'h12345678, 32'h00000000, 1'b1};
    vecs[8]  = '{32'h10,  1'b0, 3'b010, 32'h0,        32'hDEAD80EF, 1'b0};
    vecs[9]  = '{32'h400, 1'b0, 3'b010, 32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{32'h10,  1'b0, 3'b011, 32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{32'h16,  1'b1, 3'b001, 32'hFFFF8001, 32'h00000000, 1'b0};
    vecs[12] = '{32'h16,  1'b0, 3'b001, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[13] = '{32'h16,  1'b0, 3'b101, 32'h0,        32'h00008001, 1'b0};
    vecs[14] = '{32'h10,  1'b1, 3'b100, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[15] = '{32'h16,  1'b0, 3'b100, 32'h0,        32'h00000001, 1'b0};

    sel        = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready_m), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid_m), 32'd0);
    chk("reset rsp_err",   32'(rsp_err_m),   32'd0);
    chk("reset rsp_rdata", rsp_rdata_m,      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", 32'(req_ready_m), 32'd1);

    // Fill all storage through the port so the reference starts defined
    for (int w = 0; w < 256; w++) begin
      wd = $urandom();
      model(32'(w * 4), 1'b1, 3'b010, wd, m_rd, m_er);
      txn($sformatf("fill%0d", w), 32'(w * 4), 1'b1, 3'b010, wd, 0, m_rd, m_er);
    end

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      model(vecs[i].addr, vecs[i].we, vecs[i].f3, vecs[i].wd, m_rd, m_er);
      txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].f3, vecs[i].wd, 0,
          vecs[i].exp_rd, vecs[i].exp_er);
    end

    // Back-pressure: response held five cycles while new requests are offered
    model(32'h10, 1'b0, 3'b010, 32'h0, m_rd, m_er);
    txn("hold", 32'h10, 1'b0, 3'b010, 32'h0, 5, 32'hDEAD80EF, 1'b0);

    // Reset during WAIT aborts the pending store
    req_valid  = 1'b1;
    req_addr   = 32'h20;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_wdata  = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("midrst req_ready", 32'(req_ready_m), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid_m), 32'd0);
    chk("midrst rsp_rdata", rsp_rdata_m,      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst release req_ready", 32'(req_ready_m), 32'd1);
    model(32'h20, 1'b0, 3'b010, 32'h0, m_rd, m_er);
    txn("midrst reload", 32'h20, 1'b0, 3'b010, 32'h0, 0, m_rd, m_er);

    // Randomized traffic against the reference
    for (int i = 0; i < 300; i++) begin
      a  = (($urandom() & 32'd15) == 32'd0) ? $urandom() : 32'($urandom_range(0, 1100));
      we = 1'($urandom());
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom();
      model(a, we, f3, wd, m_rd, m_er);
      txn($sformatf("rand%0d", i), a, we, f3, wd, (i % 37 == 5) ? 2 : 0, m_rd, m_er);
    end

    // Zero-wait-state instance
    sel = 1'b1;
    @(negedge clk);
    txn("ws0 sw",  32'h40,  1'b1, 3'b010, 32'hCAFEF00D, 0, 32'h00000000, 1'b0);
    txn("ws0 lw",  32'h40,  1'b0, 3'b010, 32'h0,        0, 32'hCAFEF00D, 1'b0);
    txn("ws0 lb",  32'h41,  1'b0, 3'b000, 32'h0,        0, 32'hFFFFFFF0, 1'b0);
    txn("ws0 lhu", 32'h42,  1'b0, 3'b101, 32'h0,        0, 32'h0000CAFE, 1'b0);
    txn("ws0 oor", 32'h400, 1'b0, 3'b010, 32'h0,        0, 32'h00000000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words of storage (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request accept and access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  core presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned, out of range, or illegal funct3.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1; on req_valid capture addr/we/funct3/wdata; go WAIT if WAIT_STATES>0, else RESP.
REQ-017 WAIT: req_ready=0; counter loaded with WAIT_STATES-1 at accept, decrements per cycle; at 0 go RESP.
REQ-018 Memory access (read or write) SHALL occur on the transition into RESP; rsp_valid rises exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-019 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1; then go IDLE; req_ready=0 in RESP (no back-to-back overlap).
REQ-020 Word index = addr[31:2]; out of range when addr[31:2] >= DEPTH_WORDS.
REQ-021 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal funct3: 011, 110, 111, or 100/101 with req_we=1.
REQ-022 Errored request SHALL not modify memory, SHALL return rsp_err=1, rsp_rdata=0.
REQ-023 Stores SHALL write only addressed lanes: B lane addr[1:0]; H lanes {addr[1],0}/{addr[1],1}; W all four.
REQ-024 Loads: B/H sign-extend from bit 7/15 of selected lane(s); BU/HU zero-extend; W unchanged.
REQ-025 Store response: rsp_valid pulse via same handshake, rsp_rdata=0, rsp_err=0.
REQ-026 req_* inputs SHALL be ignored outside IDLE; changes after accept do not affect the transaction.

Reset
REQ-027 On rst=1 at a clock edge: state IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 during reset cycle, 1 first cycle after.
REQ-028 Reset mid-transaction SHALL abort it; a write not yet performed SHALL not occur; memory array contents SHALL NOT be cleared by reset.

Structure
REQ-029 Shared package SHALL hold funct3 width constants and FSM state encoding.
REQ-030 One sub-module dmem_lane_align SHALL hold combinational lane select, store byte-mask/data replication, load extension and misalign detection.
REQ-031 Storage SHALL be a word array of DEPTH_WORDS with per-byte write enables.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept (WAIT_STATES=1).
REQ-033 After REQ-032, SB 0x80 @0x11; LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0xDEAD80EF.
REQ-034 LH @0x13 -> rsp_err=1, rdata=0; SW 0x12345678 @0x12 -> rsp_err=1, LW @0x10 unchanged.
REQ-035 LW @0x400 (DEPTH_WORDS=256) -> rsp_err=1; funct3=011 -> rsp_err=1.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, new req_valid ignored.
REQ-037 Accept SW 0x1 @0x20, assert rst in WAIT -> IDLE next cycle, LW @0x20 returns prior value; WAIT_STATES=0 run -> rsp_valid 1 cycle after accept.
